hv_owt_rx: RTL and testbench

HV-die one-wire receiver that decodes the pulse-width-modulated frames driven by the LV core on the LV→HV isolation channel. It recovers each register-access frame (read/write flag, 7-bit address, 8-bit data, optional CRC-8), checks it and presents it to the HV register file as a single-cycle strobe. It also detects timeout, framing and CRC errors, so the HV side can flag a broken link.

---
 rtl/hv_owt_pkg.sv | 36 +++
 rtl/hv_owt_crc8.sv | 21 ++
 rtl/hv_owt_rx.sv | 188 ++++++++++++++++++
 tb/tb_hv_owt_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hv_owt_pkg.sv
// Shared definitions for the HV one-wire link: field widths, CRC polynomial, FSM states.
// HV_OWT_RX_CRC_EN selects the 24-bit frame with a trailing CRC-8; otherwise frames are 16 bits.
package hv_owt_pkg;

    localparam int RW_W         = 1;
    localparam int ADDR_W       = 7;
    localparam int DATA_W       = 8;
    localparam int CRC_W        = 8;
    localparam int PAYLOAD_BITS = RW_W + ADDR_W + DATA_W;

    localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;

`ifdef HV_OWT_RX_CRC_EN
    localparam int FRAME_BITS = PAYLOAD_BITS + CRC_W;
`else
    localparam int FRAME_BITS = PAYLOAD_BITS;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_GAP    = 3'd2,
        ST_BIT_LO = 3'd3,
        ST_BIT_HI = 3'd4,
        ST_CHECK  = 3'd5
    } owt_state_e;

    // One MSB-first step of the serial CRC.
    function automatic logic [CRC_W-1:0] crc8_next(input logic [CRC_W-1:0] crc,
                                                   input logic din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC8_POLY : '0);
    endfunction

endpackage

// File: rtl/hv_owt_crc8.sv
// Serial CRC-8 (poly 0x07, init 0x00, MSB first); shared by the LV transmitter and HV receiver.
module hv_owt_crc8
    import hv_owt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc8_next(crc, din);
        end
    end

endmodule

// File: rtl/hv_owt_rx.sv
// HV-side one-wire PWM frame receiver: sync, bit decode, optional CRC check, error strobes.
// Build option: define HV_OWT_RX_CRC_EN to append and check a CRC-8 on every frame.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle, waiting for a rising edge
// ST_SYNC   | measuring a high pulse that may be a sync
// ST_GAP    | low time after sync, waiting for the first bit cell
// ST_BIT_LO | low time between bit cells
// ST_BIT_HI | measuring a bit-cell high time
// ST_CHECK  | full frame received, checking CRC and publishing
module hv_owt_rx
    import hv_owt_pkg::*;
#(
    parameter int BIT_CYC    = 32,
    parameter int SYNC_MIN   = 3 * BIT_CYC,
    parameter int GLITCH_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lv_hv_owt_rx,
    output logic              o_frm_vld,
    output logic              o_frm_rw,
    output logic [ADDR_W-1:0] o_frm_addr,
    output logic [DATA_W-1:0] o_frm_wdata,
    output logic              o_crc_err,
    output logic              o_to_err,
    output logic              o_frm_err,
    output logic              o_busy
);

    localparam int HW = $clog2(SYNC_MIN + 1);
    localparam int LW = $clog2(2 * BIT_CYC + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);

    localparam logic [HW-1:0] SYNC_MIN_C = HW'(SYNC_MIN);
    localparam logic [HW-1:0] HI_MAX_C   = HW'(BIT_CYC);
    localparam logic [HW-1:0] HALF_C     = HW'(BIT_CYC / 2);
    localparam logic [HW-1:0] GLITCH_C   = HW'(GLITCH_CYC);
    localparam logic [LW-1:0] TO_C       = LW'(2 * BIT_CYC);

    logic sync1, sync2, lvl, rise, fall;

    owt_state_e              state, prev_lo;
    logic [HW-1:0]           hcnt;
    logic [LW-1:0]           lcnt;
    logic [BW-1:0]           bitcnt;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    bit_ok, bit_val, crc_ok;

    // Edge detect is a registered stage so lvl/rise/fall describe the same sample.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            lvl   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= i_lv_hv_owt_rx;
            sync2 <= sync1;
            lvl   <= sync2;
            rise  <= sync2 & ~lvl;
            fall  <= ~sync2 & lvl;
        end
    end

    assign bit_ok  = (state == ST_BIT_HI) && fall && (hcnt >= GLITCH_C);
    assign bit_val = (hcnt >= HALF_C);
    assign o_busy  = (state != ST_IDLE);

`ifdef HV_OWT_RX_CRC_EN
    logic [CRC_W-1:0] crc_state;
    logic             crc_clr;

    // Every frame passes through SYNC, so clearing there also covers a resync after a framing error.
    assign crc_clr = (state == ST_IDLE) || (state == ST_SYNC);

    hv_owt_crc8 u_crc (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (crc_clr),
        .en    (bit_ok),
        .din   (bit_val),
        .crc   (crc_state)
    );

    assign crc_ok = (crc_state == '0);
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            prev_lo     <= ST_GAP;
            hcnt        <= '0;
            lcnt        <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            o_frm_vld   <= 1'b0;
            o_crc_err   <= 1'b0;
            o_to_err    <= 1'b0;
            o_frm_err   <= 1'b0;
            o_frm_rw    <= 1'b0;
            o_frm_addr  <= '0;
            o_frm_wdata <= '0;
        end else begin
            o_frm_vld <= 1'b0;
            o_crc_err <= 1'b0;
            o_to_err  <= 1'b0;
            o_frm_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_SYNC;
                        hcnt  <= HW'(1);
                    end
                end

                ST_SYNC: begin
                    bitcnt <= '0;
                    if (fall) begin
                        if (hcnt >= SYNC_MIN_C) begin
                            state <= ST_GAP;
                            lcnt  <= LW'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (hcnt != SYNC_MIN_C) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end

                ST_GAP, ST_BIT_LO: begin
                    if (rise) begin
                        state   <= ST_BIT_HI;
                        prev_lo <= state;
                        hcnt    <= HW'(1);
                    end else if (lcnt == TO_C) begin
                        state    <= ST_IDLE;
                        o_to_err <= 1'b1;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end

                ST_BIT_HI: begin
                    if (fall) begin
                        if (!bit_ok) begin
                            // Glitch: resume the low phase with its count untouched.
                            state <= prev_lo;
                        end else begin
                            if (bitcnt < BW'(PAYLOAD_BITS)) begin
                                shreg <= {shreg[PAYLOAD_BITS-2:0], bit_val};
                            end
                            bitcnt <= bitcnt + 1'b1;
                            lcnt   <= LW'(1);
                            state  <= (bitcnt == BW'(FRAME_BITS - 1)) ? ST_CHECK : ST_BIT_LO;
                        end
                    end else if (hcnt == HI_MAX_C) begin
                        // Keep counting as a sync so an interrupting new frame is still caught.
                        o_frm_err <= 1'b1;
                        state     <= ST_SYNC;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end

                ST_CHECK: begin
                    state <= ST_IDLE;
                    if (crc_ok) begin
                        o_frm_vld   <= 1'b1;
                        o_frm_rw    <= shreg[PAYLOAD_BITS-1];
                        o_frm_addr  <= shreg[PAYLOAD_BITS-2 -: ADDR_W];
                        o_frm_wdata <= shreg[DATA_W-1:0];
                    end else begin
                        o_crc_err <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hv_owt_rx.sv
// Directed bench for hv_owt_rx: table of frames plus timeout, framing, glitch and reset sequences.
// Latencies are counted from the first rising clk edge that samples the new line level.
module tb_hv_owt_rx;

    localparam int B = 32;
`ifdef HV_OWT_RX_CRC_EN
    localparam int FB = 24;
`else
    localparam int FB = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line;
    logic       frm_vld, frm_rw, crc_err, to_err, frm_err, busy;
    logic [6:0] frm_addr;
    logic [7:0] frm_wdata;

    hv_owt_rx #(.BIT_CYC(B), .SYNC_MIN(3 * B), .GLITCH_CYC(2)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_lv_hv_owt_rx (line),
        .o_frm_vld      (frm_vld),
        .o_frm_rw       (frm_rw),
        .o_frm_addr     (frm_addr),
        .o_frm_wdata    (frm_wdata),
        .o_crc_err      (crc_err),
        .o_to_err       (to_err),
        .o_frm_err      (frm_err),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts, cycle of last occurrence, busy at strobe, exclusivity.
    int   n_vld = 0, n_crc = 0, n_to = 0, n_frm = 0, n_excl = 0;
    int   c_vld = 0, c_crc = 0, c_to = 0, c_frm = 0;
    logic busy_at = 1'b0;
    always @(negedge clk) begin
        if (frm_vld) begin n_vld <= n_vld + 1; c_vld <= cyc; end
        if (crc_err) begin n_crc <= n_crc + 1; c_crc <= cyc; end
        if (to_err)  begin n_to  <= n_to + 1;  c_to  <= cyc; end
        if (frm_err) begin n_frm <= n_frm + 1; c_frm <= cyc; end
        if (frm_vld | crc_err | to_err) busy_at <= busy;
        if ((int'(frm_vld) + int'(crc_err) + int'(to_err) + int'(frm_err)) > 1) n_excl <= n_excl + 1;
    end

    int n_cmp = 0, n_bad = 0;
    int last_fall, rise_s;
    int s_vld, s_crc, s_to, s_frm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        s_vld = n_vld; s_crc = n_crc; s_to = n_to; s_frm = n_frm;
    endtask

    task automatic lo(input int n);
        line = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic hi(input int n);
        line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_sync();
        hi(100);
        lo(16);
    endtask

    // Sends bits f[n-1:0] MSB first; bit index g (counted from the first sent) gets a 1-cycle glitch in its low phase.
    task automatic send_bits(input logic [23:0] f, input int n, input int g);
        logic b;
        for (int i = n - 1; i >= 0; i--) begin
            b = f[i];
            hi(b ? 24 : 8);
            line = 1'b0;
            last_fall = cyc + 1;
            if ((n - 1 - i) == g) begin
                repeat (3) @(negedge clk);
                hi(1);
                lo((b ? 8 : 24) - 4);
            end else begin
                repeat (b ? 8 : 24) @(negedge clk);
            end
        end
    endtask

    function automatic logic [7:0] crc8_model(input logic [15:0] p);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            fb = c[7] ^ p[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [23:0] mk_frame(input logic rw, input logic [6:0] a, input logic [7:0] d);
        logic [15:0] p;
        p = {rw, a, d};
`ifdef HV_OWT_RX_CRC_EN
        return {p, crc8_model(p)};
`else
        return {8'h00, p};
`endif
    endfunction

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        logic       flip;
        logic       exp_vld;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_f;
    logic [23:0] f;

    initial begin
        vecs.push_back('{1'b1, 7'h15, 8'hA5, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 7'h7F, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 7'h00, 8'hFF, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 7'h2A, 8'h5A, 1'b0, 1'b1});
`ifdef HV_OWT_RX_CRC_EN
        vecs.push_back('{1'b1, 7'h15, 8'hA5, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 7'h01, 8'h80, 1'b1, 1'b0});
`endif

        rst_n = 1'b0;
        line  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {frm_vld, frm_rw, frm_addr, frm_wdata, crc_err, to_err, frm_err, busy}, 0);
        rst_n = 1'b1;
        lo(5);
        exp_f = 16'h0000;

        foreach (vecs[k]) begin
            f = mk_frame(vecs[k].rw, vecs[k].addr, vecs[k].data);
            if (vecs[k].flip) f[0] = ~f[0];
            snap();
            send_sync();
            send_bits(f, FB, -1);
            lo(20);
            if (vecs[k].exp_vld) exp_f = {vecs[k].rw, vecs[k].addr, vecs[k].data};
            check("tbl_vld_count", n_vld - s_vld, int'(vecs[k].exp_vld));
            check("tbl_crc_count", n_crc - s_crc, int'(!vecs[k].exp_vld));
            check("tbl_other_err", (n_to - s_to) + (n_frm - s_frm), 0);
            check("tbl_latency", vecs[k].exp_vld ? (c_vld - last_fall) : (c_crc - last_fall), 4);
            check("tbl_fields", {frm_rw, frm_addr, frm_wdata}, exp_f);
            check("tbl_busy_at_strobe", busy_at, 0);
        end

        // Timeout after 7 bits, then a good read frame.
        snap();
        f = mk_frame(1'b1, 7'h33, 8'hC3);
        send_sync();
        send_bits(f >> (FB - 7), 7, -1);
        lo(100);
        check("to_count", n_to - s_to, 1);
        check("to_latency", c_to - last_fall, 2 * B + 3);
        check("to_busy_dropped", busy_at, 0);
        check("to_no_vld", n_vld - s_vld, 0);
        snap();
        send_sync();
        send_bits(mk_frame(1'b0, 7'h7F, 8'h3C), FB, -1);
        lo(20);
        exp_f = {1'b0, 7'h7F, 8'h3C};
        check("after_to_vld", n_vld - s_vld, 1);
        check("after_to_fields", {frm_rw, frm_addr, frm_wdata}, exp_f);

        // Over-long high inside the bit phase, continuing as a new sync.
        snap();
        send_sync();
        send_bits(mk_frame(1'b1, 7'h55, 8'h11) >> (FB - 5), 5, -1);
        line = 1'b1;
        rise_s = cyc + 1;
        repeat (130) @(negedge clk);
        lo(16);
        send_bits(mk_frame(1'b1, 7'h0C, 8'h96), FB, -1);
        lo(20);
        exp_f = {1'b1, 7'h0C, 8'h96};
        check("frm_count", n_frm - s_frm, 1);
        check("frm_latency", c_frm - rise_s, B + 3);
        check("frm_resync_vld", n_vld - s_vld, 1);
        check("frm_resync_fields", {frm_rw, frm_addr, frm_wdata}, exp_f);
        check("frm_no_other", (n_to - s_to) + (n_crc - s_crc), 0);

        // Short high while idle, then a frame with a 1-cycle glitch in a low phase.
        snap();
        hi(10);
        lo(20);
        check("idle_glitch_quiet", (n_vld - s_vld) + (n_crc - s_crc) + (n_to - s_to) + (n_frm - s_frm), 0);
        send_sync();
        send_bits(mk_frame(1'b0, 7'h4B, 8'hE7), FB, 5);
        lo(20);
        exp_f = {1'b0, 7'h4B, 8'hE7};
        check("glitch_vld", n_vld - s_vld, 1);
        check("glitch_fields", {frm_rw, frm_addr, frm_wdata}, exp_f);
        check("glitch_no_err", (n_crc - s_crc) + (n_to - s_to) + (n_frm - s_frm), 0);

        // Reset pulse after 12 bits discards the partial frame silently.
        f = mk_frame(1'b1, 7'h66, 8'h99);
        send_sync();
        send_bits(f >> (FB - 12), 12, -1);
        check("pre_reset_busy", busy, 1);
        snap();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", {frm_vld, frm_rw, frm_addr, frm_wdata, crc_err, to_err, frm_err, busy}, 0);
        rst_n = 1'b1;
        send_bits(f, FB - 12, -1);
        lo(30);
        check("post_reset_quiet", (n_vld - s_vld) + (n_crc - s_crc) + (n_to - s_to) + (n_frm - s_frm), 0);
        send_sync();
        send_bits(f, FB, -1);
        lo(20);
        exp_f = {1'b1, 7'h66, 8'h99};
        check("post_reset_vld", n_vld - s_vld, 1);
        check("post_reset_fields", {frm_rw, frm_addr, frm_wdata}, exp_f);
        check("post_reset_latency", c_vld - last_fall, 4);

        check("strobe_exclusive", n_excl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
